// File: rtl/shr_seq_ctrl.sv
// shr_seq_ctrl: sequencer for the 10-bit serial-in shift register (shr10).
// It accepts a word over start/busy and presets the shifter with a one-cycle ld3ff.
// It then shifts the word in MSB first, one bit per en pulse, with GAP idle cycles
// between pulses.
//
// Optional feature macro: SHR_SEQ_VERIFY_EN
//   defined   - the shifter contents are checked against the latched word on entry
//               to DONE, and err is sticky until the next accept.
//   undefined - err is tied low and q_in is ignored.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start
// PRESET | ld3ff high for one cycle, which presets the shifter to all ones
// SHIFT  | en high, si = current MSB of the word copy
// WAIT   | inter-pulse gap, en low, si already holds the next bit
// DONE   | done high for one cycle, then back to IDLE
//
// All outputs come straight from flops, so no input reaches an output combinationally.

module shr_seq_ctrl #(
    parameter int WIDTH = 10,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             ld3ff,
    output logic             en,
    output logic             si,
    input  logic [WIDTH-1:0] q_in,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESET,
        S_SHIFT,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0] C_WIDTH = 4'(WIDTH);
    localparam logic [3:0] C_GAP   = 4'(GAP);

    state_t           r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [3:0]       r_bcnt;
    logic [3:0]       r_gcnt;
    logic             r_busy;
    logic             r_ld3ff;
    logic             r_en;
    logic             r_si;
    logic             r_done;

`ifdef SHR_SEQ_VERIFY_EN
    logic [WIDTH-1:0] r_word;
    logic             r_err;
    logic             w_mismatch;

    // The last shift lands on the same edge that enters DONE. The comparison
    // therefore uses the shifter value as it will be after that edge.
    assign w_mismatch = ({q_in[WIDTH-2:0], r_sreg[WIDTH-1]} != r_word);
    assign err        = r_err;
`else
    logic w_unused_q_in;

    assign w_unused_q_in = ^q_in;
    assign err           = 1'b0;
`endif

    assign busy  = r_busy;
    assign ld3ff = r_ld3ff;
    assign en    = r_en;
    assign si    = r_si;
    assign done  = r_done;

    // Sequencer FSM. Each output flop is loaded with its value for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sreg  <= '0;
            r_bcnt  <= '0;
            r_gcnt  <= '0;
            r_busy  <= 1'b0;
            r_ld3ff <= 1'b0;
            r_en    <= 1'b0;
            r_si    <= 1'b0;
            r_done  <= 1'b0;
`ifdef SHR_SEQ_VERIFY_EN
            r_word  <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_ld3ff <= 1'b0;
            r_en    <= 1'b0;
            r_si    <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_PRESET;
                        r_sreg  <= din;
                        r_bcnt  <= C_WIDTH;
                        r_busy  <= 1'b1;
                        r_ld3ff <= 1'b1;
`ifdef SHR_SEQ_VERIFY_EN
                        r_word  <= din;
                        r_err   <= 1'b0;
`endif
                    end
                end
                S_PRESET: begin
                    r_state <= S_SHIFT;
                    r_en    <= 1'b1;
                    r_si    <= r_sreg[WIDTH-1];
                end
                S_SHIFT: begin
                    r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
                    r_bcnt <= r_bcnt - 4'd1;
                    if (r_bcnt == 4'd1) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
`ifdef SHR_SEQ_VERIFY_EN
                        r_err   <= r_err | w_mismatch;
`endif
                    end else if (GAP > 0) begin
                        r_state <= S_WAIT;
                        r_gcnt  <= C_GAP;
                        r_si    <= r_sreg[WIDTH-2];
                    end else begin
                        r_en <= 1'b1;
                        r_si <= r_sreg[WIDTH-2];
                    end
                end
                S_WAIT: begin
                    r_gcnt <= r_gcnt - 4'd1;
                    r_si   <= r_sreg[WIDTH-1];
                    if (r_gcnt == 4'd1) begin
                        r_state <= S_SHIFT;
                        r_en    <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
